// File: rtl/dsp_slice_resp_pkg.sv
// Shared opmode encodings, field positions and bus payload for the DSP48A1-style responder slice.
package dsp_slice_resp_pkg;

    localparam int unsigned OPM_W   = 8;
    localparam int unsigned AB_W    = 18;
    localparam int unsigned C_W     = 48;
    localparam int unsigned P_W     = 48;
    localparam int unsigned MUL_W   = 2 * AB_W;
    localparam int unsigned INS_W   = OPM_W + 2 * AB_W + C_W;

    // Bit offsets of the fields inside the flat 92-bit input bus
    localparam int unsigned INS_C_LSB   = 0;
    localparam int unsigned INS_B_LSB   = INS_C_LSB + C_W;
    localparam int unsigned INS_A_LSB   = INS_B_LSB + AB_W;
    localparam int unsigned INS_OPM_LSB = INS_A_LSB + AB_W;

    localparam int unsigned OPM_CIN_BIT = 5;
    localparam int unsigned OPM_SUB_BIT = 7;

    localparam logic [OPM_W-1:0] DSP_NOP       = 8'h00;
    localparam logic [OPM_W-1:0] DSP_XIN_ZERO  = 8'h00;
    localparam logic [OPM_W-1:0] DSP_XIN_MULT  = 8'h01;
    localparam logic [OPM_W-1:0] DSP_XIN_P     = 8'h02;
    localparam logic [OPM_W-1:0] DSP_XIN_AB    = 8'h03;
    localparam logic [OPM_W-1:0] DSP_ZIN_ZERO  = 8'h00;
    localparam logic [OPM_W-1:0] DSP_ZIN_PCIN  = 8'h04;
    localparam logic [OPM_W-1:0] DSP_ZIN_P     = 8'h08;
    localparam logic [OPM_W-1:0] DSP_ZIN_C     = 8'h0C;
    localparam logic [OPM_W-1:0] DSP_PREADD    = 8'h10;
    localparam logic [OPM_W-1:0] DSP_CIN       = 8'h20;
    localparam logic [OPM_W-1:0] DSP_PRESUB    = 8'h40;
    localparam logic [OPM_W-1:0] DSP_POSTSUB   = 8'h80;

    typedef struct packed {
        logic [OPM_W-1:0] opmode;
        logic [AB_W-1:0]  a;
        logic [AB_W-1:0]  b;
        logic [C_W-1:0]   c;
    } dsp_ins_t;

endpackage

// File: rtl/dsp_slice_resp_postadd48.sv
// Combinational X/Z mux and 48-bit post-adder producing result, carry/borrow and signed overflow.
module dsp_postadd48
    import dsp_slice_resp_pkg::*;
(
    input  logic [1:0]     x_sel,
    input  logic [1:0]     z_sel,
    input  logic           cin,
    input  logic           sub,
    input  logic [P_W-1:0] m,
    input  logic [P_W-1:0] ab,
    input  logic [P_W-1:0] c,
    input  logic [P_W-1:0] p,
    output logic [P_W-1:0] r_c,
    output logic           carry_c,
    output logic           ovf_c
);

    logic [P_W-1:0] x;
    logic [P_W-1:0] z;
    logic [P_W:0]   xu;
    logic [P_W:0]   ru;
    logic [P_W+1:0] xs;
    logic [P_W+1:0] zs;
    logic [P_W+1:0] rs;

    // Operand selection; PCIN has no cascade source and reads as zero
    always_comb begin
        x = '0;
        z = '0;
        case (x_sel)
            2'b01:   x = m;
            2'b10:   x = p;
            2'b11:   x = ab;
            default: x = '0;
        endcase
        case (z_sel)
            2'b10:   z = p;
            2'b11:   z = c;
            default: z = '0;
        endcase
    end

    // Unsigned 49-bit path gives P and carry; 50-bit signed path detects overflow
    always_comb begin
        xu = {1'b0, x} + (P_W+1)'(cin);
        ru = sub ? ({1'b0, z} - xu) : ({1'b0, z} + xu);
        xs = {{2{x[P_W-1]}}, x} + (P_W+2)'(cin);
        zs = {{2{z[P_W-1]}}, z};
        rs = sub ? (zs - xs) : (zs + xs);
    end

    assign r_c     = ru[P_W-1:0];
    assign carry_c = ru[P_W];
    assign ovf_c   = !((rs[P_W+1:P_W-1] == 3'b000) || (rs[P_W+1:P_W-1] == 3'b111));

endmodule

// File: rtl/dsp_slice_resp.sv
// DSP48A1-compatible responder slice: multiply, post-add, registered P with overflow/activity status.
// Define DSP_MREG_EN to add the M pipeline stage (latency 2 instead of 1).
module dsp_slice_resp
    import dsp_slice_resp_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [INS_W-1:0] dsp_ins_flat,
    output logic [P_W-1:0]   dsp_outs_flat,
    output logic             carry_out,
    output logic             ovf_sticky,
    input  logic             ovf_clr,
    output logic [CNT_W-1:0] op_count,
    input  logic             op_count_clr
);

    dsp_ins_t               ins;
    logic signed [MUL_W-1:0] mult;
    logic [P_W-1:0]         m48;
    logic [P_W-1:0]         ab48;
    logic                   issue;

    logic [OPM_W-1:0]       s_op;
    logic [P_W-1:0]         s_m;
    logic [P_W-1:0]         s_ab;
    logic [P_W-1:0]         s_c;
    logic                   exec;

    logic [P_W-1:0]         r_c;
    logic                   carry_c;
    logic                   ovf_c;

    assign ins   = dsp_ins_t'(dsp_ins_flat);
    assign mult  = MUL_W'($signed(ins.a)) * MUL_W'($signed(ins.b));
    assign m48   = P_W'(mult);
    assign ab48  = {12'h000, ins.a, ins.b};
    assign issue = (ins.opmode != DSP_NOP);

`ifdef DSP_MREG_EN
    logic [OPM_W-1:0] op_q;
    logic [P_W-1:0]   m_q;
    logic [P_W-1:0]   ab_q;
    logic [P_W-1:0]   c_q;

    // M stage: product and its controls travel together; reset leaves a NOP here
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q <= DSP_NOP;
            m_q  <= '0;
            ab_q <= '0;
            c_q  <= '0;
        end else begin
            op_q <= ins.opmode;
            m_q  <= m48;
            ab_q <= ab48;
            c_q  <= ins.c;
        end
    end

    assign s_op = op_q;
    assign s_m  = m_q;
    assign s_ab = ab_q;
    assign s_c  = c_q;
`else
    assign s_op = ins.opmode;
    assign s_m  = m48;
    assign s_ab = ab48;
    assign s_c  = ins.c;
`endif

    assign exec = (s_op != DSP_NOP);

    dsp_postadd48 u_postadd (
        .x_sel   (s_op[1:0]),
        .z_sel   (s_op[3:2]),
        .cin     (s_op[OPM_CIN_BIT]),
        .sub     (s_op[OPM_SUB_BIT]),
        .m       (s_m),
        .ab      (s_ab),
        .c       (s_c),
        .p       (dsp_outs_flat),
        .r_c     (r_c),
        .carry_c (carry_c),
        .ovf_c   (ovf_c)
    );

    // P stage and status; a NOP holds P and carry, a fresh overflow beats a clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dsp_outs_flat <= '0;
            carry_out     <= 1'b0;
            ovf_sticky    <= 1'b0;
            op_count      <= '0;
        end else begin
            if (exec) begin
                dsp_outs_flat <= r_c;
                carry_out     <= carry_c;
            end
            ovf_sticky <= (exec && ovf_c) || (ovf_sticky && !ovf_clr);
            if (op_count_clr) begin
                op_count <= '0;
            end else if (issue && !(&op_count)) begin
                op_count <= op_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_dsp_slice_resp.sv
// Directed self-checking bench for dsp_slice_resp (works with and without DSP_MREG_EN).
module tb_dsp_slice_resp;
    import dsp_slice_resp_pkg::*;

`ifdef DSP_MREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [INS_W-1:0] dsp_ins_flat = '0;
    logic [P_W-1:0]   dsp_outs_flat;
    logic             carry_out;
    logic             ovf_sticky;
    logic             ovf_clr = 1'b0;
    logic [15:0]      op_count;
    logic             op_count_clr = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [7:0]  op;
        logic [17:0] a;
        logic [17:0] b;
        logic [47:0] c;
        logic        oclr;
        logic        cclr;
        logic [47:0] ep;
        logic        ec;
        logic        eo;
        logic [15:0] en;
    } vec_t;

    vec_t vecs[17];
    logic [47:0] chain_exp[5];

    dsp_slice_resp #(.CNT_W(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .dsp_ins_flat  (dsp_ins_flat),
        .dsp_outs_flat (dsp_outs_flat),
        .carry_out     (carry_out),
        .ovf_sticky    (ovf_sticky),
        .ovf_clr       (ovf_clr),
        .op_count      (op_count),
        .op_count_clr  (op_count_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] op, input logic [17:0] a, input logic [17:0] b,
                         input logic [47:0] c, input logic oc, input logic cc);
        dsp_ins_flat = {op, a, b, c};
        ovf_clr      = oc;
        op_count_clr = cc;
    endtask

    task automatic drive_nop();
        drive(8'h00, 18'h0, 18'h0, 48'h0, 1'b0, 1'b0);
    endtask

    // One op issued at a negedge, followed by NOPs until its result is visible
    task automatic issue_vec(input vec_t v);
        @(negedge clk);
        drive(v.op, v.a, v.b, v.c, v.oclr, v.cclr);
        @(negedge clk);
        drive_nop();
        repeat (LAT - 1) @(negedge clk);
    endtask

    initial begin
        vecs[0]  = '{8'h01, 18'h00003, 18'h3FFFE, 48'h0, 1'b0, 1'b0, 48'hFFFF_FFFF_FFFA, 1'b0, 1'b0, 16'd1};
        vecs[1]  = '{8'h10, 18'h00000, 18'h00000, 48'h0, 1'b0, 1'b0, 48'h0, 1'b0, 1'b0, 16'd2};
        vecs[2]  = '{8'h8D, 18'd7, 18'd10, 48'd100, 1'b0, 1'b0, 48'd30, 1'b0, 1'b0, 16'd3};
        vecs[3]  = '{8'h81, 18'd7, 18'd10, 48'd0, 1'b0, 1'b0, 48'hFFFF_FFFF_FFBA, 1'b1, 1'b0, 16'd4};
        vecs[4]  = '{8'h00, 18'd0, 18'd0, 48'd0, 1'b0, 1'b0, 48'hFFFF_FFFF_FFBA, 1'b1, 1'b0, 16'd4};
        vecs[5]  = '{8'h2C, 18'd0, 18'd0, 48'd5, 1'b0, 1'b0, 48'd6, 1'b0, 1'b0, 16'd5};
        vecs[6]  = '{8'h0A, 18'd0, 18'd0, 48'd0, 1'b0, 1'b0, 48'd12, 1'b0, 1'b0, 16'd6};
        vecs[7]  = '{8'h03, 18'd1, 18'd2, 48'd0, 1'b0, 1'b0, 48'h4_0002, 1'b0, 1'b0, 16'd7};
        vecs[8]  = '{8'h0C, 18'd0, 18'd0, 48'h7FFF_FFFF_FFFF, 1'b0, 1'b0, 48'h7FFF_FFFF_FFFF, 1'b0, 1'b0, 16'd8};
        vecs[9]  = '{8'h0B, 18'd0, 18'd1, 48'd0, 1'b0, 1'b0, 48'h8000_0000_0000, 1'b0, 1'b1, 16'd9};
        vecs[10] = '{8'h00, 18'd0, 18'd0, 48'd0, 1'b1, 1'b0, 48'h8000_0000_0000, 1'b0, 1'b0, 16'd9};
        vecs[11] = '{8'h0C, 18'd0, 18'd0, 48'h7FFF_FFFF_FFFF, 1'b0, 1'b0, 48'h7FFF_FFFF_FFFF, 1'b0, 1'b0, 16'd10};
        vecs[12] = '{8'h0B, 18'd0, 18'd1, 48'd0, 1'b1, 1'b0, 48'h8000_0000_0000, 1'b0, 1'b1, 16'd11};
        vecs[13] = '{8'h10, 18'd0, 18'd0, 48'd0, 1'b0, 1'b1, 48'h0, 1'b0, 1'b1, 16'd0};
        vecs[14] = '{8'h00, 18'd0, 18'd0, 48'd0, 1'b1, 1'b0, 48'h0, 1'b0, 1'b0, 16'd0};
        vecs[15] = '{8'h8F, 18'd0, 18'd1, 48'h8000_0000_0000, 1'b0, 1'b0, 48'h7FFF_FFFF_FFFF, 1'b0, 1'b1, 16'd1};
        vecs[16] = '{8'h00, 18'd0, 18'd0, 48'd0, 1'b0, 1'b1, 48'h7FFF_FFFF_FFFF, 1'b0, 1'b1, 16'd0};
        chain_exp = '{48'd10, 48'd11, 48'd13, 48'd16, 48'd20};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_p", 64'(dsp_outs_flat), 64'h0);
        chk("rst_cnt", 64'(op_count), 64'h0);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_ovf", 64'(ovf_sticky), 64'h0);
        chk("rst_carry", 64'(carry_out), 64'h0);

        // Table of single operations
        for (int i = 0; i < 17; i++) begin
            issue_vec(vecs[i]);
            chk($sformatf("v%0d_p", i), 64'(dsp_outs_flat), 64'(vecs[i].ep));
            chk($sformatf("v%0d_carry", i), 64'(carry_out), 64'(vecs[i].ec));
            chk($sformatf("v%0d_ovf", i), 64'(ovf_sticky), 64'(vecs[i].eo));
            chk($sformatf("v%0d_cnt", i), 64'(op_count), 64'(vecs[i].en));
        end

        // Back-to-back accumulate chain, result of op k seen LAT negedges later
        for (int k = 0; k < 5 + LAT; k++) begin
            @(negedge clk);
            if (k >= LAT)
                chk($sformatf("chain%0d_p", k - LAT), 64'(dsp_outs_flat), 64'(chain_exp[k - LAT]));
            if (k == 0)
                drive(8'h01, 18'd2, 18'd5, 48'd0, 1'b0, 1'b1);
            else if (k < 5)
                drive(8'h09, 18'd1, 18'(k), 48'd0, 1'b0, 1'b0);
            else
                drive_nop();
        end
        chk("chain_cnt", 64'(op_count), 64'd4);

        // NOPs hold P and the counter
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("hold%0d_p", k), 64'(dsp_outs_flat), 64'd20);
            chk($sformatf("hold%0d_cnt", k), 64'(op_count), 64'd4);
        end
        issue_vec('{8'h40, 18'd0, 18'd0, 48'd0, 1'b0, 1'b0, 48'd0, 1'b0, 1'b0, 16'd5});
        chk("clr_p", 64'(dsp_outs_flat), 64'd0);
        chk("clr_cnt", 64'(op_count), 64'd5);

        // Async reset between edges during a chain
        @(negedge clk);
        drive(8'h01, 18'd2, 18'd5, 48'd0, 1'b0, 1'b0);
        @(negedge clk);
        drive(8'h09, 18'd1, 18'd1, 48'd0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_p", 64'(dsp_outs_flat), 64'd0);
        chk("arst_carry", 64'(carry_out), 64'd0);
        chk("arst_ovf", 64'(ovf_sticky), 64'd0);
        chk("arst_cnt", 64'(op_count), 64'd0);
        drive_nop();
        @(negedge clk);
        reset = 1'b1;
        issue_vec('{8'h09, 18'd1, 18'd3, 48'd0, 1'b0, 1'b0, 48'd3, 1'b0, 1'b0, 16'd1});
        chk("post_rst_p", 64'(dsp_outs_flat), 64'd3);
        chk("post_rst_cnt", 64'(op_count), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
